// File: rtl/puzzle_game_ctrl.sv
// puzzle_game_ctrl
// Game sequencer for the 4-tile permutation puzzle. It latches the starting
// board chosen on the generator, applies the player's adjacent swaps to a
// working board, detects the solved arrangement, and counts moves and the
// seconds spent playing.
//
// State table (the encoding is the game_status bus value)
//   state      | meaning
//   ST_CHOSE   | 00 board selection, board mirrors board_in
//   ST_GAMING  | 01 player swapping tiles, timer running
//   ST_INIT    | 10 one-cycle solved check on the latched board
//   ST_WIN     | 11 solved, outputs frozen until start/abort
//
// Ports
//   clk_d        in   game clock
//   rst          in   synchronous active-high reset
//   btn_start    in   debounced level, rising edge = start/confirm/leave win
//   btn_abort    in   debounced level, rising edge = give up
//   btn_move     in   debounced level, rising edge = one swap
//   move_pos     in   swap slot p with slot p+1 (3 = no-op)
//   board_in     in   generator board, slot0=[11:9] .. slot3=[2:0]
//   game_status  out  current state, see table
//   board        out  working board, same packing as board_in
//   move_count   out  valid swaps this game, saturating
//   elapsed_s    out  seconds in GAMING, saturating
//   win_pulse    out  one-cycle pulse on entry to WINNED

module puzzle_game_ctrl #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int MAX_MOVES     = 99,
    parameter int MAX_SECS      = 999
) (
    input  logic        clk_d,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_abort,
    input  logic        btn_move,
    input  logic [1:0]  move_pos,
    input  logic [11:0] board_in,
    output logic [1:0]  game_status,
    output logic [11:0] board,
    output logic [6:0]  move_count,
    output logic [9:0]  elapsed_s,
    output logic        win_pulse
);

    typedef enum logic [1:0] {
        ST_CHOSE  = 2'b00,
        ST_GAMING = 2'b01,
        ST_INIT   = 2'b10,
        ST_WIN    = 2'b11
    } state_e;

    localparam logic [11:0] SOLVED = 12'b000_001_010_011;
    localparam int          PW     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    state_e        state_q, state_d;
    logic [11:0]   board_q, board_d;
    logic [6:0]    moves_q, moves_d;
    logic [9:0]    secs_q, secs_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          win_q, win_d;
    logic          start_prev_q, abort_prev_q, move_prev_q;

    logic          ev_abort, ev_start, ev_move;
    logic [11:0]   swapped;

    function automatic logic [11:0] swap_slots(input logic [11:0] b, input logic [1:0] p);
        logic [11:0] r;
        case (p)
            2'd0:    r = {b[8:6], b[11:9], b[5:0]};
            2'd1:    r = {b[11:9], b[5:3], b[8:6], b[2:0]};
            2'd2:    r = {b[11:6], b[2:0], b[5:3]};
            default: r = b;
        endcase
        return r;
    endfunction

    // Events are resolved by priority before the state logic sees them, so a
    // lower-priority press in the same cycle is simply dropped.
    assign ev_abort = btn_abort & ~abort_prev_q;
    assign ev_start = btn_start & ~start_prev_q & ~ev_abort;
    assign ev_move  = btn_move  & ~move_prev_q  & ~ev_abort & ~ev_start;

    assign swapped = swap_slots(board_q, move_pos);

    always_ff @(posedge clk_d) begin
        if (rst) begin
            state_q      <= ST_CHOSE;
            board_q      <= SOLVED;
            moves_q      <= '0;
            secs_q       <= '0;
            presc_q      <= '0;
            win_q        <= 1'b0;
            // History tracks the live level while in reset, so a button held
            // through reset has to be released and pressed again to fire.
            start_prev_q <= btn_start;
            abort_prev_q <= btn_abort;
            move_prev_q  <= btn_move;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            moves_q      <= moves_d;
            secs_q       <= secs_d;
            presc_q      <= presc_d;
            win_q        <= win_d;
            start_prev_q <= btn_start;
            abort_prev_q <= btn_abort;
            move_prev_q  <= btn_move;
        end
    end

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        moves_d = moves_q;
        secs_d  = secs_q;
        presc_d = presc_q;
        win_d   = 1'b0;

        case (state_q)
            ST_CHOSE: begin
                board_d = board_in;
                if (ev_start) begin
                    moves_d = '0;
                    secs_d  = '0;
                    presc_d = '0;
                    state_d = ST_INIT;
                end
            end

            ST_INIT: begin
                if (board_q == SOLVED) begin
                    state_d = ST_WIN;
                    win_d   = 1'b1;
                end else begin
                    state_d = ST_GAMING;
                end
            end

            ST_GAMING: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (secs_q < 10'(MAX_SECS)) begin
                        secs_d = secs_q + 10'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end

                if (ev_abort) begin
                    state_d = ST_CHOSE;
                end else if (ev_move && move_pos != 2'd3) begin
                    board_d = swapped;
                    if (moves_q < 7'(MAX_MOVES)) begin
                        moves_d = moves_q + 7'd1;
                    end
                    if (swapped == SOLVED) begin
                        state_d = ST_WIN;
                        win_d   = 1'b1;
                    end
                end
            end

            ST_WIN: begin
                if (ev_abort || ev_start) begin
                    state_d = ST_CHOSE;
                end
            end

            default: state_d = ST_CHOSE;
        endcase
    end

    assign game_status = state_q;
    assign board       = board_q;
    assign move_count  = moves_q;
    assign elapsed_s   = secs_q;
    assign win_pulse   = win_q;

endmodule

// File: tb/tb_puzzle_game_ctrl.sv
module tb_puzzle_game_ctrl;

    localparam int T  = 4;
    localparam int MM = 3;
    localparam int MS = 5;

    localparam logic [11:0] B0123 = 12'b000_001_010_011;
    localparam logic [11:0] B1023 = 12'b001_000_010_011;
    localparam logic [11:0] B0132 = 12'b000_001_011_010;
    localparam logic [11:0] B1032 = 12'b001_000_011_010;

    logic        clk_d = 1'b0;
    logic        rst;
    logic        btn_start, btn_abort, btn_move;
    logic [1:0]  move_pos;
    logic [11:0] board_in;
    logic [1:0]  game_status;
    logic [11:0] board;
    logic [6:0]  move_count;
    logic [9:0]  elapsed_s;
    logic        win_pulse;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: tiles as an array, play time as a raw cycle count,
    // move count as the number of valid swaps; saturation applied on read.
    int         m_status;     // 0 choose, 1 gaming, 2 initial, 3 winned
    logic [2:0] mb [4];
    int         m_swaps;
    int         m_gcyc;
    bit         m_win;
    bit         l_start, l_abort, l_move;

    puzzle_game_ctrl #(.TICKS_PER_SEC(T), .MAX_MOVES(MM), .MAX_SECS(MS)) dut (
        .clk_d       (clk_d),
        .rst         (rst),
        .btn_start   (btn_start),
        .btn_abort   (btn_abort),
        .btn_move    (btn_move),
        .move_pos    (move_pos),
        .board_in    (board_in),
        .game_status (game_status),
        .board       (board),
        .move_count  (move_count),
        .elapsed_s   (elapsed_s),
        .win_pulse   (win_pulse)
    );

    always #5 clk_d = ~clk_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [11:0] m_pack();
        return {mb[0], mb[1], mb[2], mb[3]};
    endfunction

    function automatic bit m_solved();
        return mb[0] == 3'd0 && mb[1] == 3'd1 && mb[2] == 3'd2 && mb[3] == 3'd3;
    endfunction

    task automatic model_edge();
        bit a, s, m;
        int p;
        logic [2:0] t;
        if (rst) begin
            m_status = 0;
            mb[0] = 3'd0; mb[1] = 3'd1; mb[2] = 3'd2; mb[3] = 3'd3;
            m_swaps = 0;
            m_gcyc  = 0;
            m_win   = 1'b0;
        end else begin
            a = btn_abort && !l_abort;
            s = btn_start && !l_start && !a;
            m = btn_move  && !l_move  && !a && !s;
            m_win = 1'b0;
            case (m_status)
                0: begin
                    mb[0] = board_in[11:9]; mb[1] = board_in[8:6];
                    mb[2] = board_in[5:3];  mb[3] = board_in[2:0];
                    if (s) begin
                        m_swaps = 0;
                        m_gcyc  = 0;
                        m_status = 2;
                    end
                end
                2: begin
                    if (m_solved()) begin
                        m_status = 3;
                        m_win = 1'b1;
                    end else begin
                        m_status = 1;
                    end
                end
                1: begin
                    m_gcyc++;
                    if (a) begin
                        m_status = 0;
                    end else if (m && move_pos != 2'd3) begin
                        p = int'(move_pos);
                        t = mb[p]; mb[p] = mb[p+1]; mb[p+1] = t;
                        m_swaps++;
                        if (m_solved()) begin
                            m_status = 3;
                            m_win = 1'b1;
                        end
                    end
                end
                default: begin
                    if (a || s) m_status = 0;
                end
            endcase
        end
        l_start = btn_start;
        l_abort = btn_abort;
        l_move  = btn_move;
    endtask

    task automatic step();
        @(posedge clk_d);
        model_edge();
        #1;
        check("status",  32'(game_status), 32'(m_status));
        check("board",   32'(board),       32'(m_pack()));
        check("moves",   32'(move_count),  32'(imin(m_swaps, MM)));
        check("elapsed", 32'(elapsed_s),   32'(imin(m_gcyc / T, MS)));
        check("win",     32'(win_pulse),   32'(m_win));
    endtask

    // which: 0 start, 1 abort, 2 move
    task automatic press(input int which, input int hold);
        case (which)
            0: btn_start = 1'b1;
            1: btn_abort = 1'b1;
            default: btn_move = 1'b1;
        endcase
        repeat (hold) step();
        btn_start = 1'b0;
        btn_abort = 1'b0;
        btn_move  = 1'b0;
        step();
    endtask

    task automatic do_move(input logic [1:0] p);
        move_pos = p;
        press(2, 1);
    endtask

    function automatic logic [11:0] rand_board();
        logic [2:0] t [4];
        logic [2:0] x;
        int k;
        t[0] = 3'd0; t[1] = 3'd1; t[2] = 3'd2; t[3] = 3'd3;
        repeat ($urandom_range(0, 3)) begin
            k = $urandom_range(0, 2);
            x = t[k]; t[k] = t[k+1]; t[k+1] = x;
        end
        return {t[0], t[1], t[2], t[3]};
    endfunction

    initial begin
        rst = 1'b1;
        btn_start = 1'b1;
        btn_abort = 1'b0;
        btn_move  = 1'b0;
        move_pos  = 2'd0;
        board_in  = B0123;
        l_start = 1'b0; l_abort = 1'b0; l_move = 1'b0;
        m_status = 0; m_swaps = 0; m_gcyc = 0; m_win = 1'b0;
        mb[0] = 3'd0; mb[1] = 3'd1; mb[2] = 3'd2; mb[3] = 3'd3;

        // start held through reset must not fire
        step(); step();
        check("rst_status", 32'(game_status), 32'd0);
        check("rst_board",  32'(board),       32'(B0123));
        check("rst_moves",  32'(move_count),  32'd0);
        rst = 1'b0;
        repeat (3) step();
        check("held_start_status", 32'(game_status), 32'd0);
        btn_start = 1'b0;
        step();

        // already-solved board goes straight to WINNED
        btn_start = 1'b1;
        step();
        check("solved_init", 32'(game_status), 32'd2);
        btn_start = 1'b0;
        step();
        check("solved_win_status", 32'(game_status), 32'd3);
        check("solved_win_pulse",  32'(win_pulse),   32'd1);
        check("solved_win_moves",  32'(move_count),  32'd0);
        step();
        check("pulse_one_cycle", 32'(win_pulse), 32'd0);
        press(0, 1);
        check("win_start_exit", 32'(game_status), 32'd0);

        // 1023, one swap at 0 wins
        board_in = B1023;
        step();
        btn_start = 1'b1;
        step();
        check("latch_board", 32'(board), 32'(B1023));
        btn_start = 1'b0;
        step();
        check("to_gaming", 32'(game_status), 32'd1);
        move_pos = 2'd0;
        btn_move = 1'b1;
        step();
        check("win1_status", 32'(game_status), 32'd3);
        check("win1_board",  32'(board),       32'(B0123));
        check("win1_moves",  32'(move_count),  32'd1);
        check("win1_pulse",  32'(win_pulse),   32'd1);
        btn_move = 1'b0;
        step();
        check("win1_pulse_off", 32'(win_pulse), 32'd0);
        press(1, 1);

        // 0132: pos 3 is a no-op, pos 2 solves
        board_in = B0132;
        step();
        press(0, 1);
        do_move(2'd3);
        check("pos3_board", 32'(board),      32'(B0132));
        check("pos3_moves", 32'(move_count), 32'd0);
        do_move(2'd2);
        check("pos2_win", 32'(game_status), 32'd3);
        press(0, 2);

        // timing and move saturation
        board_in = B1023;
        step();
        press(0, 1);
        repeat (13) step();
        check("elapsed_13", 32'(elapsed_s), 32'd3);
        do_move(2'd2); do_move(2'd2); do_move(2'd1); do_move(2'd1); do_move(2'd2);
        check("sat_moves", 32'(move_count), 32'd3);
        check("sat_board", 32'(board),      32'(B1032));

        // abort beats move in the same cycle
        move_pos  = 2'd0;
        btn_abort = 1'b1;
        btn_move  = 1'b1;
        step();
        check("abort_status", 32'(game_status), 32'd0);
        check("abort_board",  32'(board),       32'(B1032));
        check("abort_moves",  32'(move_count),  32'd3);
        check("sat_elapsed",  32'(elapsed_s),   32'(MS));
        btn_abort = 1'b0;
        btn_move  = 1'b0;
        step();

        // randomized single-button play
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 11);
            move_pos = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                btn_move = 1'($urandom_range(0, 1));
                step();
                rst = 1'b0;
                btn_move = 1'b0;
                step();
            end else if (r <= 4) begin
                press(2, $urandom_range(1, 2));
            end else if (r <= 6) begin
                press(0, $urandom_range(1, 2));
            end else if (r == 7) begin
                press(1, 1);
            end else if (r <= 9) begin
                board_in = ($urandom_range(0, 7) == 0) ? 12'($urandom()) : rand_board();
                step();
            end else begin
                repeat ($urandom_range(1, 6)) step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
